// File: rtl/cpu_run_pkg.sv
// Shared types and default parameters for the run controller that sequences the mips core.
`timescale 1ns/1ps
package cpu_run_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } run_state_t;

  localparam int unsigned DEF_RESET_CYCLES = 5;
  localparam int unsigned DEF_PC_W         = 32;
  localparam int unsigned DEF_CNT_W        = 32;
  localparam int unsigned DEF_MAX_CYCLES   = 10000;
  localparam int unsigned DEF_STALL_LIMIT  = 4;

endpackage

// File: rtl/cpu_run_ctrl.sv
// Run controller: holds the core in reset, counts RUN cycles and commits,
// ends the run on a branch-to-self loop (DONE) or an exhausted budget (TIMEOUT).
`timescale 1ns/1ps
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int unsigned PC_W         = DEF_PC_W,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int unsigned STALL_LIMIT  = DEF_STALL_LIMIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [PC_W-1:0]  halt_pc
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned LOOP_W = $clog2(STALL_LIMIT + 1);

  run_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instr_q, instr_d;
  logic [PC_W-1:0]   halt_pc_q, halt_pc_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic              have_last_q, have_last_d;
  logic              repeat_pc;
  logic              halt;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    cycle_d     = cycle_q;
    instr_d     = instr_q;
    halt_pc_d   = halt_pc_q;
    loop_d      = loop_q;
    have_last_d = have_last_q;
    repeat_pc   = 1'b0;
    halt        = 1'b0;

    unique case (state_q)
      HOLD: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (hold_cnt_q == HOLD_W'(RESET_CYCLES - 1)) state_d = RUN;
      end
      RUN: begin
        cycle_d = cycle_q + 1'b1;
        if (pc_valid) begin
          repeat_pc   = have_last_q && (pc == halt_pc_q);
          instr_d     = instr_q + 1'b1;
          halt_pc_d   = pc;
          loop_d      = repeat_pc ? loop_q + 1'b1 : '0;
          have_last_d = 1'b1;
          halt        = repeat_pc && (loop_q == LOOP_W'(STALL_LIMIT - 1));
        end
        // A halt on the budget's last cycle takes priority over the timeout.
        if (halt)                                    state_d = DONE;
        else if (cycle_q == CNT_W'(MAX_CYCLES - 1)) state_d = TIMEOUT;
      end
      DONE, TIMEOUT: begin
        if (start) begin
          state_d     = HOLD;
          hold_cnt_d  = '0;
          cycle_d     = '0;
          instr_d     = '0;
          loop_d      = '0;
          have_last_d = 1'b0;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HOLD;
      hold_cnt_q  <= '0;
      cycle_q     <= '0;
      instr_q     <= '0;
      halt_pc_q   <= '0;
      loop_q      <= '0;
      have_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cycle_q     <= cycle_d;
      instr_q     <= instr_d;
      halt_pc_q   <= halt_pc_d;
      loop_q      <= loop_d;
      have_last_q <= have_last_d;
    end
  end

  assign cpu_reset   = (state_q == HOLD);
  assign running     = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign timeout     = (state_q == TIMEOUT);
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
  assign halt_pc     = halt_pc_q;

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Synthesizable run controller between the simulation bench and the `mips` core. It replaces the hand-timed reset pulse with a parametrised reset hold and counts cycles and committed instructions. It detects program end as a branch-to-self loop and flags a runaway program as a timeout. The bench drives only `clk`/`reset`/`start` and waits on `done`/`timeout`.

## Interface
- `RESET_CYCLES`, default 5: cycles `cpu_reset` stays high after `reset` releases; must be ≥1.
- `PC_W`, default 32: width of the observed PC.
- `CNT_W`, default 32: width of the cycle and instruction counters.
- `MAX_CYCLES`, default 10000: RUN-cycle budget before timeout; must be ≥1 and < 2^CNT_W.
- `STALL_LIMIT`, default 4: consecutive repeated commits of the same PC that declare a halt; must be ≥1.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high; overrides everything.
- `start` in 1: single-cycle pulse; rerun request, honoured only in DONE or TIMEOUT.
- `pc` in PC_W: PC of the instruction committing this cycle.
- `pc_valid` in 1: `pc` is a valid commit this cycle.
- `cpu_reset` out 1: reset to the core.
- `running` out 1: high in RUN.
- `done` out 1: halt detected; sticky until `start` or `reset`.
- `timeout` out 1: budget exhausted; sticky until `start` or `reset`.
- `cycle_count` out CNT_W: RUN cycles elapsed.
- `instr_count` out CNT_W: commits seen in RUN.
- `halt_pc` out PC_W: last committed PC.

## Operation
- States: HOLD, RUN, DONE, TIMEOUT. All outputs are registered or decoded from the state only, with no combinational input-to-output path.
- Reset values: state HOLD, `hold_cnt`=0, `cpu_reset`=1, `running`=0, `done`=0, `timeout`=0, both counts 0, `halt_pc`=0, `loop_cnt`=0, `have_last`=0.
- HOLD:
  - `cpu_reset`=1 and `hold_cnt` increments each edge.
  - On the edge where `hold_cnt`==RESET_CYCLES-1, go to RUN.
  - `pc_valid` is ignored.
- RUN:
  - `cpu_reset`=0 and `cycle_count` increments every edge.
  - On `pc_valid`:
    - `instr_count` increments and `halt_pc`<=`pc`.
    - If `have_last` and `pc`==`halt_pc`, `loop_cnt` increments; otherwise `loop_cnt`<=0.
    - `have_last`<=1.
  - Halt condition: `pc_valid`, `have_last`, `pc`==`halt_pc` and `loop_cnt`==STALL_LIMIT-1.
    - Go to DONE and set `done`.
    - That commit is still counted.
  - Timeout condition: `cycle_count`==MAX_CYCLES-1 with no halt on the same edge.
    - Go to TIMEOUT and set `timeout`.
  - Halt and timeout on the same edge: halt wins, `done`=1, `timeout`=0.
- DONE / TIMEOUT:
  - `cpu_reset`=0; all counts and `halt_pc` are frozen.
  - `start` returns to HOLD and clears `hold_cnt`, both counts, the flags, `loop_cnt` and `have_last`.
  - `halt_pc` is not cleared.
- `start` in HOLD or RUN is ignored.
- `reset` mid-RUN: next state HOLD with reset values; no flag survives.
- Counters never wrap: MAX_CYCLES < 2^CNT_W bounds `cycle_count`, and `instr_count` ≤ `cycle_count`.

## Timing
- `cpu_reset` is high while `reset` is high plus exactly RESET_CYCLES cycles after the first edge with `reset` low.
- `running` rises the cycle after the last HOLD cycle.
- `done` / `timeout` assert one cycle after the deciding edge's inputs, together with `running` falling.
- Rerun latency: `start` sampled at edge N puts `cpu_reset` high from N and RUN begins after RESET_CYCLES further edges.
- A zero-RESET bench (`reset` pulsed one cycle) is valid.

## Structure
- Package `cpu_run_pkg`:
  - `run_state_t` enum (HOLD, RUN, DONE, TIMEOUT).
  - Default-parameter localparams.
  - Shared with the bench for state decoding.
- Single module with inline counters; no sub-module is warranted.

## Test plan
Common parameters RESET_CYCLES=3, MAX_CYCLES=20, STALL_LIMIT=2 unless stated.
1. Reset release: `reset` high 2 cycles then low → `cpu_reset` high for exactly 3 cycles after release; `running`=1 on cycle 4; all counts 0.
2. Halt: commits of PCs 0x3000, 0x3004, 0x3008, 0x3008, 0x3008 on consecutive cycles → `done`=1 after the 5th commit, `instr_count`=5, `halt_pc`=0x3008, `timeout`=0.
3. Timeout: RUN with no repeated PC → `timeout`=1 after 20 RUN cycles, `cycle_count`=20, `done`=0.
4. Simultaneous events: arrange the final halting commit on RUN cycle 20 → `done`=1, `timeout`=0.
5. Rerun and abort:
   - `start` pulse in DONE → HOLD for 3 cycles, counts cleared, `done`=0.
   - `start` pulsed during RUN → ignored.
   - `reset` mid-RUN → HOLD with all reset values.
6. Repeats interrupted: PCs 0x3000, 0x3000, 0x3004, 0x3004 with STALL_LIMIT=3 → no halt, `loop_cnt` restarts at 0x3004.
